// File: rtl/imm_gen_stage.sv
// ---------------------------------------------------------------------------
// imm_gen_stage
//
// Registered immediate-generation stage for the decode pipeline. It takes the
// raw instruction field and the instruction's PC+4, builds the ALU immediate
// or the branch/jump target selected by i_mode, and registers the result
// behind valid/stall/flush control. Illegal modes produce an all-ones result,
// raise o_illegal and bump a saturating counter.
//
// Parameters
//   IMM_NB   width of the I-type immediate field (low bits of i_field)
//   JMP_NB   width of the J-type target field (all of i_field)
//   DATA_NB  datapath / result width
//   CNT_NB   width of the saturating illegal-mode counter
//   Legal only when JMP_NB + 2 < DATA_NB and DATA_NB > IMM_NB + 2.
//
// Ports
//   i_clk            rising-edge clock
//   i_reset_n        asynchronous active-low reset
//   i_valid          input fields valid this cycle
//   i_stall          hold the output register
//   i_flush          squash: next output invalid (beats i_stall)
//   i_field          instruction bits [JMP_NB-1:0]
//   i_pc_plus4       PC+4 of this instruction
//   i_mode           extension / target mode
//   i_clear_count    synchronous clear of the illegal counter
//   o_valid          registered result valid
//   o_result         registered result (qualify with o_valid)
//   o_illegal        registered: captured mode was illegal
//   o_illegal_count  saturating count of accepted illegal modes
// ---------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int IMM_NB  = 16,
    parameter int JMP_NB  = 26,
    parameter int DATA_NB = 32,
    parameter int CNT_NB  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [JMP_NB-1:0]  i_field,
    input  logic [DATA_NB-1:0] i_pc_plus4,
    input  logic [2:0]         i_mode,
    input  logic               i_clear_count,
    output logic               o_valid,
    output logic [DATA_NB-1:0] o_result,
    output logic               o_illegal,
    output logic [CNT_NB-1:0]  o_illegal_count
);

    localparam logic [2:0] MODE_SIGN  = 3'b000;
    localparam logic [2:0] MODE_ZERO  = 3'b001;
    localparam logic [2:0] MODE_UPPER = 3'b010;
    localparam logic [2:0] MODE_BOFF  = 3'b011;
    localparam logic [2:0] MODE_BTGT  = 3'b100;
    localparam logic [2:0] MODE_JUMP  = 3'b101;

    localparam logic [CNT_NB-1:0] CNT_ONE = {{(CNT_NB-1){1'b0}}, 1'b1};
    localparam logic [CNT_NB-1:0] CNT_MAX = {CNT_NB{1'b1}};

    // -----------------------------------------------------------------------
    // Immediate decode (combinational)
    // -----------------------------------------------------------------------
    logic [IMM_NB-1:0]  imm;
    logic [DATA_NB-1:0] sext;
    logic [DATA_NB-1:0] zext;
    logic [DATA_NB-1:0] upper;
    logic [DATA_NB-1:0] boff;
    logic [DATA_NB-1:0] btgt;
    logic [DATA_NB-1:0] jump;
    logic               mode_illegal;
    logic [DATA_NB-1:0] result_d;

    assign imm   = i_field[IMM_NB-1:0];
    assign sext  = {{(DATA_NB-IMM_NB){imm[IMM_NB-1]}}, imm};
    assign zext  = {{(DATA_NB-IMM_NB){1'b0}}, imm};
    assign upper = {imm, {(DATA_NB-IMM_NB){1'b0}}};
    // Word-scaled offset; top bits shifted out are simply lost.
    assign boff  = sext << 2;
    // Branch target wraps modulo 2^DATA_NB; the carry out is dropped.
    assign btgt  = i_pc_plus4 + boff;
    // Jump keeps the PC region bits above the word-aligned target field.
    assign jump  = {i_pc_plus4[DATA_NB-1:JMP_NB+2], i_field, 2'b00};

    // Modes 110 and 111 are the only undefined encodings.
    assign mode_illegal = i_mode[2] & i_mode[1];

    always_comb begin
        result_d = {DATA_NB{1'b1}};
        case (i_mode)
            MODE_SIGN:  result_d = sext;
            MODE_ZERO:  result_d = zext;
            MODE_UPPER: result_d = upper;
            MODE_BOFF:  result_d = boff;
            MODE_BTGT:  result_d = btgt;
            MODE_JUMP:  result_d = jump;
            default:    result_d = {DATA_NB{1'b1}};
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register next-state
    // -----------------------------------------------------------------------
    logic               valid_q,   valid_d;
    logic [DATA_NB-1:0] result_q,  result_nxt;
    logic               illegal_q, illegal_d;
    logic [CNT_NB-1:0]  count_q,   count_d;
    logic               normal_upd;

    // A normal update happens only when neither flush nor stall is active.
    assign normal_upd = ~i_flush & ~i_stall;

    always_comb begin
        valid_d    = valid_q;
        result_nxt = result_q;
        illegal_d  = illegal_q;
        if (i_flush) begin
            // Squash the slot but keep the last result visible.
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!i_stall) begin
            valid_d    = i_valid;
            result_nxt = result_d;
            illegal_d  = i_valid & mode_illegal;
        end
    end

    always_comb begin
        count_d = count_q;
        if (i_clear_count) begin
            count_d = '0;
        end else if (normal_upd && i_valid && mode_illegal && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_nxt;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign o_valid         = valid_q;
    assign o_result        = result_q;
    assign o_illegal       = illegal_q;
    assign o_illegal_count = count_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_stage
//
// Self-checking bench for imm_gen_stage. A behavioural model computes the
// expected registered outputs with plain integer arithmetic; a compare
// process checks every DUT output against it on each falling edge. Directed
// steps additionally pin a handful of literal values, then randomized
// stimulus runs against the model.
// ---------------------------------------------------------------------------
module tb_imm_gen_stage;

    localparam int IMM_NB  = 16;
    localparam int JMP_NB  = 26;
    localparam int DATA_NB = 32;
    localparam int CNT_NB  = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid = 1'b0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic [JMP_NB-1:0]  field = '0;
    logic [DATA_NB-1:0] pc = '0;
    logic [2:0]         mode = '0;
    logic               clr = 1'b0;

    logic               o_valid;
    logic [DATA_NB-1:0] o_result;
    logic               o_illegal;
    logic [CNT_NB-1:0]  o_illegal_count;

    int total = 0;
    int bad   = 0;

    imm_gen_stage #(
        .IMM_NB (IMM_NB),
        .JMP_NB (JMP_NB),
        .DATA_NB(DATA_NB),
        .CNT_NB (CNT_NB)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_valid        (valid),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_field        (field),
        .i_pc_plus4     (pc),
        .i_mode         (mode),
        .i_clear_count  (clr),
        .o_valid        (o_valid),
        .o_result       (o_result),
        .o_illegal      (o_illegal),
        .o_illegal_count(o_illegal_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic longint model_result(input longint f, input longint p, input int m);
        longint mask;
        longint imm;
        longint s;
        mask = (longint'(1) << DATA_NB) - 1;
        imm  = f & ((longint'(1) << IMM_NB) - 1);
        s    = (imm >= (longint'(1) << (IMM_NB - 1))) ? imm - (longint'(1) << IMM_NB) : imm;
        case (m)
            0:       return s & mask;
            1:       return imm;
            2:       return (imm << (DATA_NB - IMM_NB)) & mask;
            3:       return (s * 4) & mask;
            4:       return (p + s * 4) & mask;
            5:       return (((p >> (JMP_NB + 2)) << (JMP_NB + 2)) | (f << 2)) & mask;
            default: return mask;
        endcase
    endfunction

    longint m_result = 0;
    bit     m_valid = 0;
    bit     m_illegal = 0;
    int     m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result  <= 0;
            m_valid   <= 0;
            m_illegal <= 0;
            m_count   <= 0;
        end else begin
            if (clr)
                m_count <= 0;
            else if (!flush && !stall && valid && mode >= 6)
                m_count <= (m_count < (1 << CNT_NB) - 1) ? m_count + 1 : m_count;
            if (flush) begin
                m_valid   <= 0;
                m_illegal <= 0;
            end else if (!stall) begin
                m_valid   <= valid;
                m_result  <= model_result(longint'(field), longint'(pc), int'(mode));
                m_illegal <= valid && (mode >= 6);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_valid",   longint'(o_valid),         longint'(m_valid));
        check("cyc_result",  longint'(o_result),        m_result);
        check("cyc_illegal", longint'(o_illegal),       longint'(m_illegal));
        check("cyc_count",   longint'(o_illegal_count), longint'(m_count));
    end

    // Apply one set of inputs across one rising edge; returns at edge + 1.
    task automatic step(input bit v, input bit st, input bit fl, input logic [JMP_NB-1:0] f,
                        input logic [DATA_NB-1:0] p, input logic [2:0] m, input bit c);
        valid = v; stall = st; flush = fl; field = f; pc = p; mode = m; clr = c;
        @(posedge clk);
        #1;
        $display("step v=%0b st=%0b fl=%0b mode=%0d field=%h pc=%h clr=%0b -> valid=%0b result=%h ill=%0b cnt=%0d",
                 v, st, fl, m, f, p, c, o_valid, o_result, o_illegal, o_illegal_count);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   longint'(o_valid), 0);
        check("rst_result",  longint'(o_result), 0);
        check("rst_illegal", longint'(o_illegal), 0);
        check("rst_count",   longint'(o_illegal_count), 0);
        rst_n = 1'b1;

        // Mode decode literals
        step(1, 0, 0, 26'h0008000, 32'h0, 3'd0, 0);
        check("sign_8000", longint'(o_result), 64'hFFFF8000);
        check("sign_valid", longint'(o_valid), 1);
        step(1, 0, 0, 26'h0008000, 32'h0, 3'd1, 0);
        check("zero_8000", longint'(o_result), 64'h00008000);
        step(1, 0, 0, 26'h0001234, 32'h0, 3'd2, 0);
        check("upper_1234", longint'(o_result), 64'h12340000);
        step(1, 0, 0, 26'h000FFFF, 32'h0, 3'd3, 0);
        check("boff_ffff", longint'(o_result), 64'hFFFFFFFC);
        step(1, 0, 0, 26'h0000008, 32'hFFFFFFF0, 3'd4, 0);
        check("btgt_wrap", longint'(o_result), 64'h00000010);
        step(1, 0, 0, 26'h3FFFFFF, 32'hA0000004, 3'd5, 0);
        check("jump", longint'(o_result), 64'hAFFFFFFC);

        // Stall holds everything while inputs change
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(0, 1), 1, 0, 26'($urandom), $urandom, 3'($urandom_range(0, 7)), 0);
            check("stall_result", longint'(o_result), 64'hAFFFFFFC);
            check("stall_valid", longint'(o_valid), 1);
        end
        step(1, 1, 1, 26'h0000001, 32'h0, 3'd7, 0);
        check("flush_valid", longint'(o_valid), 0);
        check("flush_result", longint'(o_result), 64'hAFFFFFFC);
        check("flush_count", longint'(o_illegal_count), 0);

        // Counter saturation
        for (int i = 0; i < 300; i++) step(1, 0, 0, 26'($urandom), $urandom, 3'd7, 0);
        check("sat_result", longint'(o_result), 64'hFFFFFFFF);
        check("sat_illegal", longint'(o_illegal), 1);
        check("sat_count", longint'(o_illegal_count), 255);
        step(1, 0, 0, 26'h0, 32'h0, 3'd6, 1);
        check("clear_wins", longint'(o_illegal_count), 0);
        check("clear_illegal", longint'(o_illegal), 1);

        // Asynchronous reset between edges
        step(1, 0, 0, 26'h0001234, 32'h0, 3'd2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", longint'(o_valid), 0);
        check("async_result", longint'(o_result), 0);
        check("async_count", longint'(o_illegal_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Invalid illegal input does not count
        step(1, 0, 0, 26'h0, 32'h0, 3'd6, 0);
        step(1, 0, 0, 26'h0, 32'h0, 3'd7, 0);
        step(0, 0, 0, 26'h0, 32'h0, 3'd6, 0);
        check("inv_count", longint'(o_illegal_count), 2);
        check("inv_illegal", longint'(o_illegal), 0);
        check("inv_result", longint'(o_result), 64'hFFFFFFFF);

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 26'($urandom), $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 49) == 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
